// File: rtl/stepper_motion_controller.sv
// Move sequencer for a 28BYJ-48 unipolar stepper: runs a commanded number of
// steps in wave/double/half mode with a linear accel/decel ramp on the step period.
module stepper_motion_controller #(
  parameter int DIV_WIDTH = 24,
  parameter int CNT_WIDTH = 16,
  parameter int START_DIV = 2500000,
  parameter int MIN_DIV   = 100000,
  parameter int ACC_DEC   = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 direcc,
  input  logic [1:0]           modo,
  input  logic [CNT_WIDTH-1:0] num_pasos,
  input  logic                 stop,
  output logic [3:0]           bobinasMotor,
  output logic                 busy,
  output logic                 done,
  output logic                 ledDirecc,
  output logic [CNT_WIDTH-1:0] pasos_restantes
);

  localparam int DW1 = DIV_WIDTH + 1;
  localparam logic [DIV_WIDTH-1:0] START_P = DIV_WIDTH'(START_DIV);
  localparam logic [DIV_WIDTH-1:0] MIN_P   = DIV_WIDTH'(MIN_DIV);
  localparam logic [DIV_WIDTH:0]   START_W = DW1'(START_DIV);
  localparam logic [DIV_WIDTH:0]   ACC_W   = DW1'(ACC_DEC);
  localparam logic [DIV_WIDTH:0]   DN_LIM  = DW1'(MIN_DIV) + DW1'(ACC_DEC);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [2:0]           p;
  logic                 dir_l;
  logic                 half_l;
  logic [DIV_WIDTH-1:0] per;
  logic [DIV_WIDTH-1:0] cyc;
  logic [CNT_WIDTH-1:0] ramp;

  logic [2:0]           p_align;
  logic [2:0]           p_next;
  logic [2:0]           inc;
  logic                 step_evt;
  logic [CNT_WIDTH-1:0] new_rem;
  logic [DIV_WIDTH:0]   per_sum;
  logic [DIV_WIDTH-1:0] per_up;
  logic [DIV_WIDTH-1:0] per_dn;
  logic [DIV_WIDTH-1:0] per_nx;
  logic [CNT_WIDTH-1:0] ramp_nx;

  function automatic logic [3:0] coil_pat(input logic [2:0] ph);
    case (ph)
      3'd0:    coil_pat = 4'b1000;
      3'd1:    coil_pat = 4'b1100;
      3'd2:    coil_pat = 4'b0100;
      3'd3:    coil_pat = 4'b0110;
      3'd4:    coil_pat = 4'b0010;
      3'd5:    coil_pat = 4'b0011;
      3'd6:    coil_pat = 4'b0001;
      default: coil_pat = 4'b1001;
    endcase
  endfunction

  always_comb begin
    case (modo)
      2'b00:   p_align = {p[2:1], 1'b0};
      2'b10:   p_align = p;
      default: p_align = {p[2:1], 1'b1};
    endcase

    inc      = half_l ? 3'd1 : 3'd2;
    p_next   = dir_l ? p + inc : p - inc;
    step_evt = (cyc == per - DIV_WIDTH'(1));
    new_rem  = pasos_restantes - CNT_WIDTH'(1);

    // Widened sums keep the saturating limits exact without wrap.
    per_sum = {1'b0, per} + ACC_W;
    per_up  = (per_sum > START_W) ? START_P : per_sum[DIV_WIDTH-1:0];
    per_dn  = ({1'b0, per} < DN_LIM) ? MIN_P : per - DIV_WIDTH'(ACC_DEC);

    if (new_rem <= ramp) begin
      per_nx  = per_up;
      ramp_nx = (ramp == '0) ? '0 : ramp - CNT_WIDTH'(1);
    end else begin
      per_nx  = per_dn;
      ramp_nx = (per_dn != per && ramp != '1) ? ramp + CNT_WIDTH'(1) : ramp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      p               <= '0;
      dir_l           <= 1'b0;
      half_l          <= 1'b0;
      per             <= START_P;
      cyc             <= '0;
      ramp            <= '0;
      bobinasMotor    <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      ledDirecc       <= 1'b0;
      pasos_restantes <= '0;
    end else begin
      case (state)
        IDLE: begin
          bobinasMotor <= '0;
          busy         <= 1'b0;
          done         <= 1'b0;
          if (start) begin
            dir_l           <= direcc;
            half_l          <= (modo == 2'b10);
            p               <= p_align;
            per             <= START_P;
            cyc             <= '0;
            ramp            <= '0;
            pasos_restantes <= num_pasos;
            ledDirecc       <= direcc;
            busy            <= 1'b1;
            if (num_pasos == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state        <= RUN;
              bobinasMotor <= coil_pat(p_align);
            end
          end
        end
        RUN: begin
          if (stop) begin
            state        <= DONE;
            done         <= 1'b1;
            bobinasMotor <= '0;
          end else if (step_evt) begin
            p               <= p_next;
            pasos_restantes <= new_rem;
            cyc             <= '0;
            per             <= per_nx;
            ramp            <= ramp_nx;
            if (new_rem == '0) begin
              state        <= DONE;
              done         <= 1'b1;
              bobinasMotor <= '0;
            end else begin
              bobinasMotor <= coil_pat(p_next);
            end
          end else begin
            cyc <= cyc + DIV_WIDTH'(1);
          end
        end
        DONE: begin
          state        <= IDLE;
          done         <= 1'b0;
          busy         <= 1'b0;
          bobinasMotor <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_motion_controller.sv
// Directed bench for stepper_motion_controller: a per-cycle expected trace of
// {coils, busy, done, ledDirecc, pasos_restantes} is queued per move and popped each cycle.
module tb_stepper_motion_controller;

  localparam int S  = 8;
  localparam int MN = 4;
  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        direcc;
  logic [1:0]  modo;
  logic [15:0] num_pasos;
  logic        stop;
  logic [3:0]  bobinasMotor;
  logic        busy;
  logic        done;
  logic        ledDirecc;
  logic [15:0] pasos_restantes;

  typedef logic [22:0] exp_t;
  exp_t sbq[$];

  int checks   = 0;
  int failures = 0;
  logic [2:0] mp;

  always #5 clk = ~clk;

  stepper_motion_controller #(
    .DIV_WIDTH(24),
    .CNT_WIDTH(16),
    .START_DIV(S),
    .MIN_DIV(MN),
    .ACC_DEC(AC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .direcc(direcc),
    .modo(modo),
    .num_pasos(num_pasos),
    .stop(stop),
    .bobinasMotor(bobinasMotor),
    .busy(busy),
    .done(done),
    .ledDirecc(ledDirecc),
    .pasos_restantes(pasos_restantes)
  );

  function automatic logic [3:0] tab(input logic [2:0] i);
    logic [3:0] t [8];
    t = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    return t[i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model of one move; pushes one expected sample per clock.
  task automatic model_move(input logic d, input logic [1:0] m, input int n, input int stop_cycle);
    int per, ramp, rem, cnt, k, inc, pn;
    bit fin;
    if (m == 2'b00) mp[0] = 1'b0;
    else if (m != 2'b10) mp[0] = 1'b1;
    inc = (m == 2'b10) ? 1 : 2;
    rem = n;
    if (n == 0) begin
      sbq.push_back({4'b0000, 1'b1, 1'b1, d, 16'd0});
    end else begin
      per = S; ramp = 0; cnt = 0; k = 0; fin = 0;
      while (!fin) begin
        sbq.push_back({tab(mp), 1'b1, 1'b0, d, 16'(rem)});
        if (k == stop_cycle) begin
          sbq.push_back({4'b0000, 1'b1, 1'b1, d, 16'(rem)});
          fin = 1;
        end else if (cnt == per - 1) begin
          mp  = d ? 3'(mp + inc) : 3'(mp - inc);
          rem = rem - 1;
          if (rem <= ramp) begin
            per = (per + AC > S) ? S : per + AC;
            if (ramp > 0) ramp--;
          end else begin
            pn = (per - AC < MN) ? MN : per - AC;
            if (pn != per) ramp++;
            per = pn;
          end
          cnt = 0;
          if (rem == 0) begin
            sbq.push_back({4'b0000, 1'b1, 1'b1, d, 16'd0});
            fin = 1;
          end
        end else begin
          cnt++;
        end
        k++;
      end
    end
    sbq.push_back({4'b0000, 1'b0, 1'b0, d, 16'(rem)});
  endtask

  task automatic run_move(input string tag, input logic d, input logic [1:0] m, input int n,
                          input int stop_cycle, input int glitch_cycle, input int exp_busy,
                          input logic stop_at_launch);
    int k = 0;
    int bcnt = 0;
    int dcnt = 0;
    exp_t e;
    model_move(d, m, n, stop_cycle);
    direcc = d; modo = m; num_pasos = 16'(n); start = 1'b1; stop = stop_at_launch;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk($sformatf("%s_c%0d", tag, k),
          32'({bobinasMotor, busy, done, ledDirecc, pasos_restantes}), 32'(e));
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) dcnt++;
      stop = (k == stop_cycle);
      if (k == glitch_cycle) begin
        start = 1'b1; num_pasos = 16'(n + 5); direcc = ~d; modo = 2'b10;
      end else begin
        start = 1'b0;
      end
      k++;
      @(posedge clk); #1;
    end
    stop = 1'b0; start = 1'b0;
    if (exp_busy > 0) chk({tag, "_busy_len"}, 32'(bcnt), 32'(exp_busy));
    chk({tag, "_done_pulses"}, 32'(dcnt), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; direcc = 1'b0; modo = 2'b00; num_pasos = '0; stop = 1'b0;
    mp = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'({bobinasMotor, busy, done, ledDirecc, pasos_restantes}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ramp: periods 8,6,4,4,6,8 -> 36 RUN cycles plus one DONE cycle
    run_move("ramp", 1'b1, 2'b01, 6, -1, -1, 37, 1'b0);

    // Reset in mid-move
    direcc = 1'b1; modo = 2'b01; num_pasos = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_reset", 32'({bobinasMotor, busy, done, ledDirecc, pasos_restantes}), 32'd0);
    mp = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_reset_idle_%0d", i), 32'({busy, done}), 32'd0);
    end

    run_move("half", 1'b0, 2'b10, 3, -1, -1, 23, 1'b0);
    run_move("zero", 1'b1, 2'b00, 0, 0, -1, 1, 1'b0);
    run_move("abort", 1'b1, 2'b00, 10, 14, -1, 16, 1'b0);
    chk("abort_rem", 32'(pasos_restantes), 32'd8);
    run_move("ignored_start", 1'b0, 2'b01, 4, -1, 3, 0, 1'b0);
    run_move("mode11", 1'b1, 2'b11, 3, -1, -1, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
